// File: rtl/stereo_sample_fifo.sv
// stereo_sample_fifo: synchronises the ADC word strobe, queues stereo pairs and streams them out FWFT with drop accounting
module stereo_sample_fifo #(
  parameter int WIDTH       = 24,
  parameter int DEPTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_stb,
  input  logic [WIDTH-1:0] in_left,
  input  logic [WIDTH-1:0] in_right,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_left,
  output logic [WIDTH-1:0] m_right,
  output logic [$clog2(DEPTH):0] level,
  output logic             overflow,
  output logic [15:0]      drop_count,
  input  logic             clr_ovf
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [SYNC_STAGES-1:0] sync_q, fill_q;
  logic                   s_d_q, armed_q, armed_d;
  logic [AW-1:0]          wptr_q, rptr_q;
  logic [LW-1:0]          level_q, level_d;
  logic                   ovf_q, ovf_d;
  logic [15:0]            drop_q, drop_d;
  logic [2*WIDTH-1:0]     mem [DEPTH];
  logic                   s, cap, full, pop, wr, drop;
  // fill_q marks when the synchroniser holds real in_stb samples, so a strobe high across reset is not mistaken for a fresh edge
  always_comb begin
    s       = sync_q[SYNC_STAGES-1];
    cap     = armed_q & s & ~s_d_q;
    full    = level_q == LW'(DEPTH);
    m_valid = level_q != '0;
    pop     = m_valid & m_ready;
    wr      = cap & (~full | pop);
    drop    = cap & full & ~pop;
    armed_d = armed_q | (fill_q[SYNC_STAGES-1] & ~s);
    level_d = (wr & ~pop) ? level_q + LW'(1) : (pop & ~wr) ? level_q - LW'(1) : level_q;
    ovf_d   = drop | (ovf_q & ~clr_ovf);
    drop_d  = clr_ovf ? {15'd0, drop} : (drop & (drop_q != 16'hFFFF)) ? drop_q + 16'd1 : drop_q;
    {m_left, m_right} = m_valid ? mem[rptr_q] : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      fill_q  <= '0;
      s_d_q   <= 1'b0;
      armed_q <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], in_stb};
      fill_q  <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      s_d_q   <= s;
      armed_q <= armed_d;
      wptr_q  <= wr ? wptr_q + AW'(1) : wptr_q;
      rptr_q  <= pop ? rptr_q + AW'(1) : rptr_q;
      level_q <= level_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr) mem[wptr_q] <= {in_left, in_right};
  end
  assign level      = level_q;
  assign overflow   = ovf_q;
  assign drop_count = drop_q;
endmodule

// File: tb/tb_stereo_sample_fifo.sv
// tb_stereo_sample_fifo: directed stimulus with a queue scoreboard checked by an independent output monitor
module tb_stereo_sample_fifo;
  logic        clk = 0, rst = 1, in_stb = 1, m_ready = 0, clr_ovf = 0;
  logic [23:0] in_left = 0, in_right = 0, m_left, m_right;
  logic        m_valid, overflow;
  logic [4:0]  level;
  logic [15:0] drop_count;
  int          checks = 0, errors = 0;
  logic [47:0] exp_q [$];
  stereo_sample_fifo dut (
    .clk(clk), .rst(rst), .in_stb(in_stb), .in_left(in_left), .in_right(in_right),
    .m_valid(m_valid), .m_ready(m_ready), .m_left(m_left), .m_right(m_right),
    .level(level), .overflow(overflow), .drop_count(drop_count), .clr_ovf(clr_ovf)
  );
  always #5 clk = ~clk;
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask
  task automatic strobe(input logic [23:0] l, input logic [23:0] r, input bit keep);
    in_left = l;
    in_right = r;
    if (keep) exp_q.push_back({l, r});
    in_stb = 1;
    tick(4);
    in_stb = 0;
    tick(4);
  endtask
  task automatic drain();
    m_ready = 1;
    tick(24);
    m_ready = 0;
    chk("drained_level", 48'(level), 48'd0);
  endtask
  always @(negedge clk) begin
    if (!rst && m_valid && m_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected got=%0h want=none", {m_left, m_right});
      end else begin
        logic [47:0] e;
        e = exp_q.pop_front();
        if ({m_left, m_right} !== e) begin
          errors++;
          $display("FAIL sb_data got=%0h want=%0h", {m_left, m_right}, e);
        end
      end
    end
  end
  initial begin
    tick(3);
    chk("rst_valid", 48'(m_valid), 48'd0);
    chk("rst_level", 48'(level), 48'd0);
    chk("rst_ovf", 48'(overflow), 48'd0);
    chk("rst_drop", 48'(drop_count), 48'd0);
    chk("rst_data", {m_left, m_right}, 48'd0);
    rst = 0;
    tick(10);
    chk("held_stb_no_write", 48'(level), 48'd0);
    in_stb = 0;
    tick(4);
    strobe(24'h0000A1, 24'h0000B1, 1);
    chk("rearm_write", 48'(level), 48'd1);
    drain();
    rst = 1;
    tick(2);
    rst = 0;
    tick(4);
    in_left = 24'h123456;
    in_right = 24'hABCDEF;
    in_stb = 1;
    exp_q.push_back({24'h123456, 24'hABCDEF});
    tick(1);
    chk("lat_k", 48'(m_valid), 48'd0);
    tick(1);
    chk("lat_k1", 48'(m_valid), 48'd0);
    tick(1);
    chk("lat_k2", 48'(m_valid), 48'd1);
    chk("lat_data", {m_left, m_right}, {24'h123456, 24'hABCDEF});
    tick(3);
    chk("hold_data", {m_left, m_right}, {24'h123456, 24'hABCDEF});
    chk("hold_valid", 48'(m_valid), 48'd1);
    in_stb = 0;
    tick(4);
    drain();
    chk("empty_zero", {m_left, m_right}, 48'd0);
    for (int i = 0; i < 16; i++) strobe(24'h100000 + 24'(i), 24'hF00000 ^ 24'(i), 1);
    chk("full_level", 48'(level), 48'd16);
    chk("full_ovf", 48'(overflow), 48'd0);
    in_left = 24'h777777;
    in_right = 24'h888888;
    exp_q.push_back({24'h777777, 24'h888888});
    in_stb = 1;
    tick(2);
    m_ready = 1;
    tick(1);
    m_ready = 0;
    in_stb = 0;
    tick(4);
    chk("coinc_level", 48'(level), 48'd16);
    chk("coinc_ovf", 48'(overflow), 48'd0);
    for (int i = 0; i < 3; i++) strobe(24'hDEAD00 + 24'(i), 24'hBEEF00, 0);
    chk("drop_level", 48'(level), 48'd16);
    chk("drop_ovf", 48'(overflow), 48'd1);
    chk("drop_cnt", 48'(drop_count), 48'd3);
    clr_ovf = 1;
    tick(1);
    clr_ovf = 0;
    chk("clr_ovf", 48'(overflow), 48'd0);
    chk("clr_cnt", 48'(drop_count), 48'd0);
    drain();
    for (int i = 0; i < 16; i++) strobe(24'h200000 + 24'(i), 24'h0F0000 + 24'(i), 1);
    force dut.drop_q = 16'hFFFE;
    #1;
    release dut.drop_q;
    tick(1);
    strobe(24'h1, 24'h2, 0);
    chk("sat_reach", 48'(drop_count), 48'hFFFF);
    strobe(24'h3, 24'h4, 0);
    chk("sat_hold", 48'(drop_count), 48'hFFFF);
    chk("sat_ovf", 48'(overflow), 48'd1);
    in_stb = 1;
    tick(2);
    clr_ovf = 1;
    tick(1);
    clr_ovf = 0;
    chk("clr_drop_ovf", 48'(overflow), 48'd1);
    chk("clr_drop_cnt", 48'(drop_count), 48'd1);
    in_stb = 0;
    tick(4);
    clr_ovf = 1;
    tick(1);
    clr_ovf = 0;
    chk("clr2_ovf", 48'(overflow), 48'd0);
    chk("clr2_cnt", 48'(drop_count), 48'd0);
    drain();
    fork
      for (int i = 0; i < 40; i++) strobe(24'h300000 + 24'(i * 3), 24'h400000 - 24'(i), 1);
      begin
        repeat (330) begin
          m_ready = ~m_ready;
          tick(1);
        end
      end
    join
    drain();
    chk("stream_ovf", 48'(overflow), 48'd0);
    chk("stream_drop", 48'(drop_count), 48'd0);
    in_stb = 1;
    tick(4);
    rst = 1;
    tick(1);
    rst = 0;
    tick(6);
    chk("midrst_level", 48'(level), 48'd0);
    in_stb = 0;
    tick(4);
    strobe(24'h55AA55, 24'hAA55AA, 1);
    chk("midrst_rearm", 48'(level), 48'd1);
    drain();
    chk("sb_empty", 48'(exp_q.size()), 48'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
